// File: rtl/quant_recip_scheduler.sv
// rtl/quant_recip_scheduler.sv - round-robin shared reciprocal-multiply quantizer
// Requests are arbitrated, scaled by a table reciprocal and rounded over two register stages.
module quant_recip_scheduler #(
    parameter int NREQ   = 4,
    parameter int DW     = 10,
    parameter int RW     = 18,
    parameter int QDEPTH = 8,
    parameter int QAW    = 3,
    localparam int IW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*DW-1:0]  req_coef,
    input  logic [NREQ*QAW-1:0] req_qidx,
    input  logic                cfg_we,
    input  logic [QAW-1:0]      cfg_addr,
    input  logic [RW-1:0]       cfg_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DW-1:0]       out_quot,
    output logic [IW-1:0]       out_id,
    output logic                busy
);

    localparam logic [DW+RW:0] HALF = (DW+RW+1)'(1) << (RW-1);

    logic [RW-1:0]   tbl [QDEPTH];
    logic [IW-1:0]   ptr;
    logic            s1_v;
    logic [DW-1:0]   s1_coef;
    logic [RW-1:0]   s1_recip;
    logic [IW-1:0]   s1_id;

    logic            stall;
    logic            found;
    logic            accept;
    logic [IW-1:0]   gnt;
    logic [DW-1:0]   sel_coef;
    logic [QAW-1:0]  sel_qidx;
    logic [DW+RW-1:0] prod;
    logic [DW+RW:0]  rnd;

    assign stall  = out_valid && !out_ready;
    assign accept = found && !stall;
    assign busy   = s1_v || out_valid;

    // Two passes give a rotating priority: first ptr..NREQ-1, then 0..ptr-1.
    always_comb begin
        found    = 1'b0;
        gnt      = '0;
        sel_coef = '0;
        sel_qidx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req_valid[i] && i >= int'(ptr)) begin
                found    = 1'b1;
                gnt      = IW'(i);
                sel_coef = req_coef[i*DW +: DW];
                sel_qidx = req_qidx[i*QAW +: QAW];
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req_valid[i] && i < int'(ptr)) begin
                found    = 1'b1;
                gnt      = IW'(i);
                sel_coef = req_coef[i*DW +: DW];
                sel_qidx = req_qidx[i*QAW +: QAW];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[gnt] = 1'b1;
        end
    end

    // Rounded product fits in DW+RW+1 bits; quotient is the DW bits above the fraction.
    assign prod = {{RW{1'b0}}, s1_coef} * {{DW{1'b0}}, s1_recip};
    assign rnd  = {1'b0, prod} + HALF;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < QDEPTH; i++) begin
                tbl[i] <= '0;
            end
        end else if (cfg_we) begin
            tbl[cfg_addr] <= cfg_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= '0;
            s1_v      <= 1'b0;
            s1_coef   <= '0;
            s1_recip  <= '0;
            s1_id     <= '0;
            out_valid <= 1'b0;
            out_quot  <= '0;
            out_id    <= '0;
        end else if (!stall) begin
            s1_v <= accept;
            if (accept) begin
                s1_coef  <= sel_coef;
                s1_recip <= tbl[sel_qidx];
                s1_id    <= gnt;
                ptr      <= (gnt == IW'(NREQ-1)) ? '0 : gnt + 1'b1;
            end
            out_valid <= s1_v;
            out_quot  <= rnd[RW +: DW];
            out_id    <= s1_id;
        end
    end

endmodule

// File: tb/tb_quant_recip_scheduler.sv
// tb/tb_quant_recip_scheduler.sv - directed self-checking bench for quant_recip_scheduler
module tb_quant_recip_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [39:0] req_coef;
    logic [11:0] req_qidx;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [17:0] cfg_data;
    logic        out_valid;
    logic        out_ready;
    logic [9:0]  out_quot;
    logic [1:0]  out_id;
    logic        busy;

    int total = 0;
    int bad   = 0;

    quant_recip_scheduler dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_coef  (req_coef),
        .req_qidx  (req_qidx),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_quot  (out_quot),
        .out_id    (out_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [9:0] c, input logic [2:0] q);
        req_coef[i*10 +: 10] = c;
        req_qidx[i*3 +: 3]   = q;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic cfg_write(input logic [2:0] a, input logic [17:0] d);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        step();
        cfg_we   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_coef  = '0;
        req_qidx  = '0;
        cfg_we    = 1'b0;
        cfg_addr  = '0;
        cfg_data  = '0;
        out_ready = 1'b1;
        step();
        step();
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_out_quot", 32'(out_quot), 0);
        chk("rst_out_id", 32'(out_id), 0);
        step();
        rst = 1'b0;
        step();

        cfg_write(3'd1, 18'd87381);
        cfg_write(3'd2, 18'd65536);

        // 300 * (1/3) -> 100, requester 0
        set_req(0, 10'd300, 3'd1);
        req_valid = 4'b0001;
        #1;
        chk("t1_ready", 32'(req_ready), 32'b0001);
        step();
        req_valid = '0;
        #1;
        chk("t1_lat_valid", 32'(out_valid), 0);
        chk("t1_busy", 32'(busy), 1);
        step();
        #1;
        chk("t1_valid", 32'(out_valid), 1);
        chk("t1_quot", 32'(out_quot), 100);
        chk("t1_id", 32'(out_id), 0);
        step();
        #1;
        chk("t1_drain_valid", 32'(out_valid), 0);
        chk("t1_drain_busy", 32'(busy), 0);

        // 1023 / 4 rounds up to 256, requester 2 (ptr is 1)
        set_req(2, 10'd1023, 3'd2);
        req_valid = 4'b0100;
        #1;
        chk("t2_ready", 32'(req_ready), 32'b0100);
        step();
        req_valid = '0;
        step();
        #1;
        chk("t2_quot", 32'(out_quot), 256);
        chk("t2_id", 32'(out_id), 2);
        step();

        // all four streaming with ptr=3: grants 3,0,1,2,3,0; quotient is (g+1)*10
        for (int i = 0; i < 4; i++) set_req(i, 10'((i + 1) * 40), 3'd2);
        for (int k = 0; k < 8; k++) begin
            req_valid = (k < 6) ? 4'hF : 4'h0;
            #1;
            if (k < 6) chk("t3_ready", 32'(req_ready), 32'(1 << ((3 + k) % 4)));
            if (k >= 2) begin
                chk("t3_valid", 32'(out_valid), 1);
                chk("t3_id", 32'(out_id), 32'((3 + k - 2) % 4));
                chk("t3_quot", 32'(out_quot), 32'((((3 + k - 2) % 4) + 1) * 10));
            end
            step();
        end
        #1;
        chk("t3_end_valid", 32'(out_valid), 0);

        // stall for 5 cycles with ids 1 (output) and 2 (stage 1) in flight
        req_valid = 4'hF;
        #1;
        chk("t4_ready_a", 32'(req_ready), 32'b0010);
        step();
        #1;
        chk("t4_ready_b", 32'(req_ready), 32'b0100);
        step();
        out_ready = 1'b0;
        for (int j = 0; j < 5; j++) begin
            #1;
            chk("t4_stall_ready", 32'(req_ready), 0);
            chk("t4_stall_valid", 32'(out_valid), 1);
            chk("t4_stall_id", 32'(out_id), 1);
            chk("t4_stall_quot", 32'(out_quot), 20);
            step();
        end
        out_ready = 1'b1;
        #1;
        chk("t4_resume_ready", 32'(req_ready), 32'b1000);
        step();
        req_valid = '0;
        #1;
        chk("t4_r_id2", 32'(out_id), 2);
        chk("t4_r_quot2", 32'(out_quot), 30);
        step();
        #1;
        chk("t4_r_id3", 32'(out_id), 3);
        chk("t4_r_quot3", 32'(out_quot), 40);
        step();
        #1;
        chk("t4_end_valid", 32'(out_valid), 0);
        chk("t4_end_busy", 32'(busy), 0);

        // table write in the accept cycle: lookup sees old 1/3 -> 3, then 1/2 -> 5
        set_req(1, 10'd10, 3'd1);
        req_valid = 4'b0010;
        cfg_we    = 1'b1;
        cfg_addr  = 3'd1;
        cfg_data  = 18'd131072;
        #1;
        chk("t5_ready_a", 32'(req_ready), 32'b0010);
        step();
        cfg_we    = 1'b0;
        req_valid = '0;
        step();
        #1;
        chk("t5_quot_old", 32'(out_quot), 3);
        chk("t5_id_old", 32'(out_id), 1);
        step();
        req_valid = 4'b0010;
        #1;
        chk("t5_ready_b", 32'(req_ready), 32'b0010);
        step();
        req_valid = '0;
        step();
        #1;
        chk("t5_quot_new", 32'(out_quot), 5);
        step();

        // boundaries: max recip with max coef, and an unwritten (zero) entry
        cfg_write(3'd3, 18'd262143);
        set_req(2, 10'd1023, 3'd3);
        set_req(3, 10'd1023, 3'd4);
        req_valid = 4'b1100;
        #1;
        chk("t6_ready_a", 32'(req_ready), 32'b0100);
        step();
        req_valid = 4'b1000;
        #1;
        chk("t6_ready_b", 32'(req_ready), 32'b1000);
        step();
        req_valid = '0;
        #1;
        chk("t6_max_quot", 32'(out_quot), 1023);
        chk("t6_max_id", 32'(out_id), 2);
        step();
        #1;
        chk("t6_zero_quot", 32'(out_quot), 0);
        chk("t6_zero_id", 32'(out_id), 3);
        step();

        // reset mid-stream: grants 1 then 2 leave ptr at 3
        set_req(2, 10'd10, 3'd1);
        req_valid = 4'b0110;
        step();
        step();
        req_valid = '0;
        #1;
        chk("t7_pre_valid", 32'(out_valid), 1);
        rst = 1'b1;
        #1;
        chk("t7_rst_valid", 32'(out_valid), 0);
        chk("t7_rst_busy", 32'(busy), 0);
        step();
        rst = 1'b0;
        set_req(3, 10'd10, 3'd1);
        req_valid = 4'b1010;
        #1;
        chk("t7_ptr_ready", 32'(req_ready), 32'b0010);
        step();
        req_valid = '0;
        step();
        #1;
        chk("t7_valid", 32'(out_valid), 1);
        chk("t7_quot", 32'(out_quot), 0);
        chk("t7_id", 32'(out_id), 1);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
